qsn_pipe: RTL and testbench

QSN_PIPE -- requirements
Module: qsn_pipe

---
 rtl/qsn_pkg.sv | 24 ++
 rtl/qsn_pipe_if.sv | 32 +++
 rtl/qsn_rot_stage.sv | 61 ++++++
 rtl/qsn_pipe.sv | 66 ++++++
 tb/tb_qsn_pipe.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qsn_pkg.sv
// Shared types and helpers for the QSN cyclic-shift pipeline.
// QSN_PIPE_DIR_EN adds a per-beat direction bit to the sideband.
package qsn_pkg;

  // Widest shift supported (LIFT_Z up to 64).
  localparam int unsigned QSN_MAX_SHIFT_W = 6;

  typedef struct packed {
`ifdef QSN_PIPE_DIR_EN
    logic                       dir;
`endif
    logic [QSN_MAX_SHIFT_W-1:0] shift;
  } qsn_side_t;

  function automatic int unsigned qsn_shift_w(input int unsigned z);
    int unsigned w;
    w = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((32'd1 << k) < z) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/qsn_pipe_if.sv
// Valid/ready beat interface for qsn_pipe (input and output channels).
// QSN_PIPE_DIR_EN adds in_dir to the input channel.
interface qsn_pipe_if #(
  parameter int unsigned LIFT_Z = 8,
  parameter int unsigned ELEM_W = 1
);
  localparam int unsigned SHIFT_W = qsn_pkg::qsn_shift_w(LIFT_Z);

  logic                       in_valid;
  logic                       in_ready;
  logic [LIFT_Z*ELEM_W-1:0]   in_data;
  logic [SHIFT_W-1:0]         in_shift;
`ifdef QSN_PIPE_DIR_EN
  logic                       in_dir;
`endif
  logic                       out_valid;
  logic                       out_ready;
  logic [LIFT_Z*ELEM_W-1:0]   out_data;

`ifdef QSN_PIPE_DIR_EN
  modport master (output in_valid, in_data, in_shift, in_dir, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_shift, in_dir, out_ready,
                  output in_ready, out_valid, out_data);
`else
  modport master (output in_valid, in_data, in_shift, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_shift, out_ready,
                  output in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/qsn_rot_stage.sv
// One barrel stage: rotates by 2^STAGE_K elements when the beat's shift bit K is set,
// then registers data, sideband and valid. QSN_PIPE_DIR_EN enables inverse rotation.
module qsn_rot_stage
  import qsn_pkg::*;
#(
  parameter int unsigned LIFT_Z  = 8,
  parameter int unsigned ELEM_W  = 1,
  parameter int unsigned STAGE_K = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_adv,
  input  logic                     i_valid,
  input  logic [LIFT_Z*ELEM_W-1:0] i_data,
  input  qsn_side_t                i_side,
  output logic                     o_valid,
  output logic [LIFT_Z*ELEM_W-1:0] o_data,
  output qsn_side_t                o_side
);
  localparam int unsigned AMT = 32'd1 << STAGE_K;

  logic [LIFT_Z*ELEM_W-1:0] w_rot;
  logic [LIFT_Z*ELEM_W-1:0] r_data;
  qsn_side_t                r_side;
  logic                     r_valid;

  always_comb begin
    w_rot = i_data;
    if (i_side.shift[STAGE_K]) begin
      for (int unsigned i = 0; i < LIFT_Z; i++) begin
`ifdef QSN_PIPE_DIR_EN
        w_rot[i*ELEM_W +: ELEM_W] = i_side.dir
          ? i_data[((i + LIFT_Z - AMT) % LIFT_Z)*ELEM_W +: ELEM_W]
          : i_data[((i + AMT) % LIFT_Z)*ELEM_W +: ELEM_W];
`else
        w_rot[i*ELEM_W +: ELEM_W] = i_data[((i + AMT) % LIFT_Z)*ELEM_W +: ELEM_W];
`endif
      end
    end
  end

  // Payload only loads on a valid beat; a bubble just clears the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_side  <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_rot;
        r_side <= i_side;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_side  = r_side;

endmodule

// File: rtl/qsn_pipe.sv
// Pipelined QSN cyclic shifter: out element i = in element (i + shift) mod LIFT_Z.
// Define QSN_PIPE_DIR_EN to add per-beat in_dir (1 = inverse rotation).
module qsn_pipe
  import qsn_pkg::*;
#(
  parameter int unsigned LIFT_Z = 8,
  parameter int unsigned ELEM_W = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  qsn_pipe_if.slave  bus
);
  localparam int unsigned SHIFT_W = qsn_shift_w(LIFT_Z);
  localparam int unsigned DATA_W  = LIFT_Z * ELEM_W;

  logic              w_adv;
  qsn_side_t         w_side_in;
  logic [SHIFT_W-1:0] w_valid;
  logic [DATA_W-1:0] w_data [SHIFT_W];
  qsn_side_t         w_side [SHIFT_W];

  always_comb begin
    w_side_in       = '0;
    w_side_in.shift = QSN_MAX_SHIFT_W'(bus.in_shift);
`ifdef QSN_PIPE_DIR_EN
    w_side_in.dir   = bus.in_dir;
`endif
  end

  // Global advance: everything moves unless the last stage holds an unaccepted beat,
  // which also lets bubbles collapse whenever the output is not stalled.
  assign w_adv = !(w_valid[SHIFT_W-1] && !bus.out_ready);

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    if (k == 0) begin : g_first
      qsn_rot_stage #(.LIFT_Z(LIFT_Z), .ELEM_W(ELEM_W), .STAGE_K(0)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_adv   (w_adv),
        .i_valid (bus.in_valid),
        .i_data  (bus.in_data),
        .i_side  (w_side_in),
        .o_valid (w_valid[k]),
        .o_data  (w_data[k]),
        .o_side  (w_side[k])
      );
    end else begin : g_next
      qsn_rot_stage #(.LIFT_Z(LIFT_Z), .ELEM_W(ELEM_W), .STAGE_K(k)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_adv   (w_adv),
        .i_valid (w_valid[k-1]),
        .i_data  (w_data[k-1]),
        .i_side  (w_side[k-1]),
        .o_valid (w_valid[k]),
        .o_data  (w_data[k]),
        .o_side  (w_side[k])
      );
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = w_valid[SHIFT_W-1];
  assign bus.out_data  = w_data[SHIFT_W-1];

endmodule

// File: tb/tb_qsn_pipe.sv
// Directed and random checks of qsn_pipe for (LIFT_Z, ELEM_W) = (8,4), (8,1), (2,4), (64,1).
module tb_qsn_pipe;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [63:0] q_a[$];
  logic [63:0] q_c[$];
  logic [63:0] q_d[$];

  qsn_pipe_if #(.LIFT_Z(8),  .ELEM_W(4)) ifa ();
  qsn_pipe_if #(.LIFT_Z(8),  .ELEM_W(1)) ifb ();
  qsn_pipe_if #(.LIFT_Z(2),  .ELEM_W(4)) ifc ();
  qsn_pipe_if #(.LIFT_Z(64), .ELEM_W(1)) ifd ();

  qsn_pipe #(.LIFT_Z(8),  .ELEM_W(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  qsn_pipe #(.LIFT_Z(8),  .ELEM_W(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  qsn_pipe #(.LIFT_Z(2),  .ELEM_W(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  qsn_pipe #(.LIFT_Z(64), .ELEM_W(1)) u_d (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotation: element i takes element (i+s) mod z, or (i-s) mod z when dir=1.
  function automatic logic [63:0] rot_model(input logic [63:0] d, input int unsigned z,
                                            input int unsigned ew, input int unsigned s,
                                            input logic dir);
    logic [63:0] r;
    int unsigned src;
    r = '0;
    for (int unsigned i = 0; i < z; i++) begin
      src = dir ? (i + z - s) % z : (i + s) % z;
      for (int unsigned b = 0; b < ew; b++) r[i*ew + b] = d[src*ew + b];
    end
    return r;
  endfunction

  task automatic idle_all(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; ifc.in_valid = 1'b0; ifd.in_valid = 1'b0;
      ifa.out_ready = 1'b1; ifb.out_ready = 1'b1; ifc.out_ready = 1'b1; ifd.out_ready = 1'b1;
    end
  endtask

  task automatic set_dir_a(input logic dir);
`ifdef QSN_PIPE_DIR_EN
    ifa.in_dir = dir;
`else
    if (dir) $display("note: in_dir ignored in forward-only build");
`endif
  endtask

  // Send one beat on instance a; lat = clock edges from accept edge to first out_valid sample.
  task automatic run_one_a(input logic [31:0] d, input logic [2:0] s, input logic dir,
                           output logic [31:0] got, output int lat);
    lat = -1;
    got = '0;
    idle_all(5);
    @(negedge clk);
    ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_shift = s; set_dir_a(dir);
    #4;
    if (!ifa.in_ready) return;
    @(posedge clk);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (ifa.out_valid) begin
        lat = k;
        got = ifa.out_data;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; ifc.in_valid = 1'b0; ifd.in_valid = 1'b0;
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0; ifc.out_ready = 1'b0; ifd.out_ready = 1'b0;
    ifa.in_data = '0; ifb.in_data = '0; ifc.in_data = '0; ifd.in_data = '0;
    ifa.in_shift = '0; ifb.in_shift = '0; ifc.in_shift = '0; ifd.in_shift = '0;
`ifdef QSN_PIPE_DIR_EN
    ifa.in_dir = 1'b0; ifb.in_dir = 1'b0; ifc.in_dir = 1'b0; ifd.in_dir = 1'b0;
`endif
    #12;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got %h exp 0", ifa.out_data); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", ifa.in_ready); end
    n_cmp++; if (ifd.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_d_out_valid got %b exp 0", ifd.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int lat;
    logic [7:0] got;
    lat = -1;
    got = '0;
    idle_all(3);
    @(negedge clk);
    ifb.in_valid = 1'b1; ifb.in_data = 8'b0000_0001; ifb.in_shift = 3'd3;
    #4;
    n_cmp++; if (ifb.in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready got %b exp 1", ifb.in_ready); end
    @(posedge clk);
    @(negedge clk);
    ifb.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (ifb.out_valid) begin lat = k; got = ifb.out_data; break; end
      @(negedge clk);
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL single_latency got %0d exp 3", lat); end
    n_cmp++; if (got !== 8'b0010_0000) begin n_bad++; $display("FAIL single_data got %b exp 00100000", got); end
  endtask

  task automatic test_vector;
    logic [31:0] got;
    int lat;
    run_one_a(32'h7654_3210, 3'd5, 1'b0, got, lat);
    n_cmp++; if (got !== 32'h4321_0765) begin n_bad++; $display("FAIL vec_fwd5 got %h exp 43210765", got); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL vec_fwd5_lat got %0d exp 3", lat); end
    run_one_a(32'hDEAD_BEEF, 3'd0, 1'b0, got, lat);
    n_cmp++; if (got !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL vec_identity got %h exp deadbeef", got); end
    run_one_a(32'h7654_3210, 3'd7, 1'b0, got, lat);
    n_cmp++; if (got !== 32'h6543_2107) begin n_bad++; $display("FAIL vec_fwd7 got %h exp 65432107", got); end
`ifdef QSN_PIPE_DIR_EN
    run_one_a(32'h7654_3210, 3'd5, 1'b1, got, lat);
    n_cmp++; if (got !== 32'h2107_6543) begin n_bad++; $display("FAIL vec_inv5 got %h exp 21076543", got); end
`endif
  endtask

  task automatic test_back_to_back;
    int nout;
    logic [63:0] e;
    nout = 0;
    q_a.delete();
    idle_all(5);
    set_dir_a(1'b0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      ifa.out_ready = 1'b1;
      ifa.in_valid  = (c < 8);
      ifa.in_data   = 32'h7654_3210 ^ (32'h1111_1111 * (c % 2));
      ifa.in_shift  = 3'(c);
      #4;
      if (ifa.in_valid && ifa.in_ready)
        q_a.push_back(rot_model({32'h0, ifa.in_data}, 8, 4, c, 1'b0));
      if (ifa.out_valid) begin
        n_cmp++; if (c !== nout + 3) begin n_bad++; $display("FAIL b2b_timing got cycle %0d exp %0d", c, nout + 3); end
        e = (q_a.size() > 0) ? q_a.pop_front() : 64'hX;
        n_cmp++; if (ifa.out_data !== e[31:0]) begin n_bad++; $display("FAIL b2b_data got %h exp %h", ifa.out_data, e[31:0]); end
        nout++;
      end
    end
    n_cmp++; if (nout !== 8) begin n_bad++; $display("FAIL b2b_count got %0d exp 8", nout); end
  endtask

  task automatic test_stall;
    logic [31:0] tab [5];
    logic [2:0]  sh  [5];
    logic [31:0] held;
    logic [63:0] e;
    int bi;
    int nout;
    tab = '{32'h7654_3210, 32'hFEDC_BA98, 32'h0F1E_2D3C, 32'hA5A5_5A5A, 32'h1234_5678};
    sh  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    bi = 0; nout = 0; held = '0;
    q_a.delete();
    idle_all(5);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ifa.out_ready = (c >= 8);
      ifa.in_valid  = (bi < 5);
      ifa.in_data   = tab[bi % 5];
      ifa.in_shift  = sh[bi % 5];
      #4;
      if (c == 3) held = ifa.out_data;
      if (c >= 3 && c <= 7) begin
        n_cmp++; if (ifa.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c%0d got %b exp 0", c, ifa.in_ready); end
        n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== held) begin
          n_bad++; $display("FAIL stall_hold c%0d got %b/%h exp 1/%h", c, ifa.out_valid, ifa.out_data, held); end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        q_a.push_back(rot_model({32'h0, ifa.in_data}, 8, 4, 32'(ifa.in_shift), 1'b0));
        bi++;
      end
      if (ifa.out_valid && ifa.out_ready) begin
        e = (q_a.size() > 0) ? q_a.pop_front() : 64'hX;
        n_cmp++; if (ifa.out_data !== e[31:0]) begin n_bad++; $display("FAIL stall_data got %h exp %h", ifa.out_data, e[31:0]); end
        nout++;
      end
      @(posedge clk);
    end
    n_cmp++; if (nout !== 5 || q_a.size() != 0) begin
      n_bad++; $display("FAIL stall_count got %0d out/%0d left exp 5/0", nout, q_a.size()); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got;
    int lat;
    int seen;
    seen = 0;
    idle_all(5);
    @(negedge clk);
    ifa.in_valid = 1'b1; ifa.in_data = 32'h7654_3210; ifa.in_shift = 3'd1;
    @(negedge clk);
    ifa.in_data = 32'hFEDC_BA98; ifa.in_shift = 3'd2;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifa.out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got %b exp 1", ifa.out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b exp 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_data got %h exp 0", ifa.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_ghost got %0d beats exp 0", seen); end
    run_one_a(32'h0F1E_2D3C, 3'd6, 1'b0, got, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rstmid_lat got %0d exp 3", lat); end
    n_cmp++; if (got !== 32'h1E2D_3C0F) begin n_bad++; $display("FAIL rstmid_data2 got %h exp 1e2d3c0f", got); end
  endtask

  task automatic test_random;
    localparam int NB = 10000;
    int sa, sc, sd, ra, rc, rd;
    logic [63:0] e;
    sa = 0; sc = 0; sd = 0; ra = 0; rc = 0; rd = 0;
    q_a.delete(); q_c.delete(); q_d.delete();
    idle_all(5);
    for (int cyc = 0; cyc < 60000 && (ra < NB || rc < NB || rd < NB); cyc++) begin
      @(negedge clk);
      ifa.in_valid = (sa < NB) && ($urandom_range(0, 3) != 0);
      ifc.in_valid = (sc < NB) && ($urandom_range(0, 3) != 0);
      ifd.in_valid = (sd < NB) && ($urandom_range(0, 3) != 0);
      ifa.out_ready = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifd.out_ready = ($urandom_range(0, 3) != 0);
      ifa.in_data = $urandom; ifc.in_data = 8'($urandom); ifd.in_data = {$urandom, $urandom};
      ifa.in_shift = 3'($urandom); ifc.in_shift = 1'($urandom); ifd.in_shift = 6'($urandom);
`ifdef QSN_PIPE_DIR_EN
      ifa.in_dir = 1'($urandom); ifc.in_dir = 1'($urandom); ifd.in_dir = 1'($urandom);
`endif
      #4;
      if (ifa.in_valid && ifa.in_ready) begin
`ifdef QSN_PIPE_DIR_EN
        q_a.push_back(rot_model({32'h0, ifa.in_data}, 8, 4, 32'(ifa.in_shift), ifa.in_dir));
`else
        q_a.push_back(rot_model({32'h0, ifa.in_data}, 8, 4, 32'(ifa.in_shift), 1'b0));
`endif
        sa++;
      end
      if (ifc.in_valid && ifc.in_ready) begin
`ifdef QSN_PIPE_DIR_EN
        q_c.push_back(rot_model({56'h0, ifc.in_data}, 2, 4, 32'(ifc.in_shift), ifc.in_dir));
`else
        q_c.push_back(rot_model({56'h0, ifc.in_data}, 2, 4, 32'(ifc.in_shift), 1'b0));
`endif
        sc++;
      end
      if (ifd.in_valid && ifd.in_ready) begin
`ifdef QSN_PIPE_DIR_EN
        q_d.push_back(rot_model(ifd.in_data, 64, 1, 32'(ifd.in_shift), ifd.in_dir));
`else
        q_d.push_back(rot_model(ifd.in_data, 64, 1, 32'(ifd.in_shift), 1'b0));
`endif
        sd++;
      end
      if (ifa.out_valid && ifa.out_ready) begin
        e = (q_a.size() > 0) ? q_a.pop_front() : 64'hX;
        n_cmp++; if (ifa.out_data !== e[31:0]) begin n_bad++; $display("FAIL rand_z8 beat %0d got %h exp %h", ra, ifa.out_data, e[31:0]); end
        ra++;
      end
      if (ifc.out_valid && ifc.out_ready) begin
        e = (q_c.size() > 0) ? q_c.pop_front() : 64'hX;
        n_cmp++; if (ifc.out_data !== e[7:0]) begin n_bad++; $display("FAIL rand_z2 beat %0d got %h exp %h", rc, ifc.out_data, e[7:0]); end
        rc++;
      end
      if (ifd.out_valid && ifd.out_ready) begin
        e = (q_d.size() > 0) ? q_d.pop_front() : 64'hX;
        n_cmp++; if (ifd.out_data !== e) begin n_bad++; $display("FAIL rand_z64 beat %0d got %h exp %h", rd, ifd.out_data, e); end
        rd++;
      end
      @(posedge clk);
    end
    n_cmp++; if (ra !== NB || rc !== NB || rd !== NB) begin
      n_bad++; $display("FAIL rand_count got %0d/%0d/%0d exp %0d each", ra, rc, rd, NB); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_vector();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    idle_all(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
